// File: rtl/des_f_stage.sv
// des_f_stage: registered DES round function f(R,K) with valid/ready handshake on both sides.
// Define DES_F_PIPE2_EN to register X between the key XOR and the S-boxes (2-cycle latency).

module des_f_sbox #(
   parameter logic [2:0] NUM = 3'd0
) (
   input  logic [5:0] din,
   output logic [3:0] dout
);

   // One 64-bit word per S-box row; column 0 sits in the top nibble.
   localparam logic [63:0] ROWS [0:31] = '{
      64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
      64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
      64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
      64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
      64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
      64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
      64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
      64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B
   };

   logic [63:0] rowBits;
   logic [3:0]  col;

   always_comb begin
      rowBits = ROWS[{NUM, din[5], din[0]}];
      col     = din[4:1];
      dout    = rowBits[{~col, 2'b00} +: 4];
   end

endmodule

module des_f_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] r_in,
   input  logic [47:0] k_in,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] f_out
);

   localparam int E_TAB [0:47] = '{
      32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
       8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
      16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
      24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1
   };

   localparam int P_TAB [0:31] = '{
      16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
       2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25
   };

   logic [47:0] xNow;
   logic [47:0] xSbox;
   logic [31:0] sBits;
   logic [31:0] fNext;

   // Tables are in DES 1-based MSB-first numbering, hence the 32-n / 47-i flips.
   for (genvar i = 0; i < 48; i++) begin : g_expand
      assign xNow[47-i] = r_in[32-E_TAB[i]] ^ k_in[47-i];
   end

   for (genvar j = 0; j < 8; j++) begin : g_sbox
      des_f_sbox #(.NUM(3'(j))) u_sbox (
         .din  (xSbox[47-6*j -: 6]),
         .dout (sBits[31-4*j -: 4])
      );
   end

   for (genvar i = 0; i < 32; i++) begin : g_perm
      assign fNext[31-i] = sBits[32-P_TAB[i]];
   end

`ifdef DES_F_PIPE2_EN
   logic [47:0] xReg;
   logic        v1;
   logic        outReadyInt;

   assign outReadyInt = !out_valid || out_ready;
   assign in_ready    = !v1 || outReadyInt;
   assign xSbox       = xReg;

   // Stage 1 holds X; stage 2 holds f. Each advances when the stage after it can take data.
   always_ff @(posedge clk) begin
      if (rst) begin
         v1        <= 1'b0;
         xReg      <= '0;
         out_valid <= 1'b0;
         f_out     <= '0;
      end else begin
         if (in_ready) begin
            v1 <= in_valid;
            if (in_valid) xReg <= xNow;
         end
         if (outReadyInt) begin
            out_valid <= v1;
            if (v1) f_out <= fNext;
         end
      end
   end
`else
   assign in_ready = !out_valid || out_ready;
   assign xSbox    = xNow;

   // Output register reloads whenever it is empty or being drained this cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         f_out     <= '0;
      end else if (in_ready) begin
         out_valid <= in_valid;
         if (in_valid) f_out <= fNext;
      end
   end
`endif

endmodule

// File: tb/tb_des_f_stage.sv
// tb_des_f_stage: directed and random checks of des_f_stage against a table-driven DES f model.
// Build with DES_F_PIPE2_EN defined to exercise the pipelined variant.

module tb_des_f_stage;

`ifdef DES_F_PIPE2_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   localparam logic [31:0] KNOWN_R = 32'hF0AAF0AA;
   localparam logic [47:0] KNOWN_K = 48'h1B02EFFC7072;
   localparam logic [31:0] KNOWN_F = 32'h234AA9BB;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] r_in;
   logic [47:0] k_in;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] f_out;

   int tests = 0;
   int fails = 0;
   int accepted = 0;

   logic [31:0] sbq [$];
   logic        holdPending = 1'b0;
   logic [31:0] holdVal = '0;

   always #5 clk = ~clk;

   des_f_stage dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .r_in      (r_in),
      .k_in      (k_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .f_out     (f_out)
   );

   // Published DES S-boxes, row-major: entry [box*64 + row*16 + col].
   localparam int SBOX [0:511] = '{
      14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,  0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
       4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0, 15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13,
      15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,  3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
       0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15, 13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9,
      10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8, 13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
      13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,  1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12,
       7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15, 13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
      10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,  3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14,
       2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9, 14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
       4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14, 11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3,
      12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11, 10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
       9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,  4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13,
       4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1, 13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
       1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,  6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12,
      13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,  1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
       7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,  2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11
   };

   localparam int PT [0:31] = '{
      16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
       2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25
   };

   // Each 6-bit E group b spans R bits 4b..4b+5 (1-based), wrapping around the 32-bit word.
   function automatic logic [47:0] model_x(input logic [31:0] r, input logic [47:0] k);
      logic [47:0] e;
      int src;
      e = '0;
      for (int i = 0; i < 48; i++) begin
         src = ((4 * (i / 6) + (i % 6) + 31) % 32) + 1;
         e[6'(47 - i)] = r[5'(32 - src)];
      end
      return e ^ k;
   endfunction

   function automatic logic [31:0] model_s(input logic [31:0] r, input logic [47:0] k);
      logic [47:0] x;
      logic [5:0]  six;
      logic [31:0] s;
      int row;
      int col;
      x = model_x(r, k);
      s = '0;
      for (int j = 0; j < 8; j++) begin
         six = 6'(x >> (42 - 6 * j));
         row = 2 * int'(six[5]) + int'(six[0]);
         col = int'(six[4:1]);
         s = s | (32'(SBOX[9'(j * 64 + row * 16 + col)]) << (28 - 4 * j));
      end
      return s;
   endfunction

   function automatic logic [31:0] model_f(input logic [31:0] r, input logic [47:0] k);
      logic [31:0] s;
      logic [31:0] f;
      s = model_s(r, k);
      f = '0;
      for (int i = 0; i < 32; i++) f[5'(31 - i)] = s[5'(32 - PT[i])];
      return f;
   endfunction

   task automatic checkOutput(input string name, input logic [47:0] actual, input logic [47:0] expected);
      tests++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [31:0] r, input logic [47:0] k);
      in_valid = v;
      r_in     = r;
      k_in     = k;
   endtask

   // Advance n rising edges, withdrawing in_valid once the DUT has taken the word.
   task automatic runCycles(input int n);
      logic acc;
      repeat (n) begin
         @(negedge clk);
         acc = in_valid && in_ready && !rst;
         @(posedge clk);
         #1;
         if (acc) in_valid = 1'b0;
      end
   endtask

   // Scoreboard: every accepted input queues its model result; every valid output must match the head.
   always @(negedge clk) begin
      if (rst) begin
         sbq.delete();
         holdPending = 1'b0;
      end else begin
         if (holdPending) checkOutput("hold", 48'(f_out), 48'(holdVal));
         if (out_valid) begin
            if (sbq.size() == 0) checkOutput("unexpected_valid", 48'(out_valid), 48'd0);
            else begin
               checkOutput("stream", 48'(f_out), 48'(sbq[0]));
               if (out_ready) void'(sbq.pop_front());
            end
         end
`ifndef DES_F_PIPE2_EN
         checkOutput("ready_rule", 48'(in_ready), 48'(!out_valid || out_ready));
`endif
         holdPending = out_valid && !out_ready;
         holdVal     = f_out;
         if (in_valid && in_ready) begin
            sbq.push_back(model_f(r_in, k_in));
            accepted++;
         end
      end
   end

   initial begin
      logic [47:0] rk;
      int startCount;

      checkOutput("pin_x", model_x(KNOWN_R, KNOWN_K), 48'h6117BA866527);
      checkOutput("pin_s", 48'(model_s(KNOWN_R, KNOWN_K)), 48'h5C82B597);
      checkOutput("pin_f", 48'(model_f(KNOWN_R, KNOWN_K)), 48'(KNOWN_F));
      checkOutput("pin_s_zero", 48'(model_s(32'h0, 48'h0)), 48'hEFA72C4D);
      checkOutput("pin_s8", 48'(model_s(32'h0, 48'h1)), 48'hEFA72C41);

      rst = 1'b1;
      out_ready = 1'b1;
      applyStimulus(1'b0, '0, '0);
      runCycles(3);
      checkOutput("reset_valid", 48'(out_valid), 48'd0);
      checkOutput("reset_f", 48'(f_out), 48'd0);
      checkOutput("reset_ready", 48'(in_ready), 48'd1);
      rst = 1'b0;
      runCycles(1);

      // Known vector followed immediately by R=0,K=0.
      applyStimulus(1'b1, KNOWN_R, KNOWN_K);
      runCycles(1);
      applyStimulus(1'b1, 32'h0, 48'h0);
      for (int e = 0; e <= LAT; e++) begin
         checkOutput("b2b_ready", 48'(in_ready), 48'd1);
         checkOutput("b2b_valid", 48'(out_valid), 48'(e >= LAT - 1));
         if (e == LAT - 1) checkOutput("known_f", 48'(f_out), 48'(KNOWN_F));
         runCycles(1);
      end
      runCycles(LAT + 1);
      checkOutput("empty_valid", 48'(out_valid), 48'd0);

      // Backpressure: known vector stalled for 5 cycles with a second word waiting.
      out_ready = 1'b0;
      applyStimulus(1'b1, KNOWN_R, KNOWN_K);
      runCycles(1);
      applyStimulus(1'b1, 32'h0, 48'h1);
      for (int e = 0; e < 5; e++) begin
         checkOutput("bp_ready", 48'(in_ready), 48'(e < LAT - 1));
         if (e >= LAT - 1) begin
            checkOutput("bp_valid", 48'(out_valid), 48'd1);
            checkOutput("bp_f", 48'(f_out), 48'(KNOWN_F));
         end
         runCycles(1);
      end
      out_ready = 1'b1;
      runCycles(1);
      checkOutput("bp_second_valid", 48'(out_valid), 48'd1);
      checkOutput("bp_second_f", 48'(f_out), 48'(model_f(32'h0, 48'h1)));
      runCycles(LAT + 1);
      checkOutput("bp_drain_valid", 48'(out_valid), 48'd0);
      checkOutput("bp_drain_queue", 48'(sbq.size()), 48'd0);

      // S8 path.
      applyStimulus(1'b1, 32'h0, 48'h1);
      runCycles(LAT);
      checkOutput("s8_valid", 48'(out_valid), 48'd1);
      checkOutput("s8_f", 48'(f_out), 48'(model_f(32'h0, 48'h1)));
      runCycles(2);

      // Reset while a result is stalled at the output.
      out_ready = 1'b0;
      applyStimulus(1'b1, KNOWN_R, KNOWN_K);
      runCycles(LAT + 1);
      checkOutput("rst_pre_valid", 48'(out_valid), 48'd1);
      rst = 1'b1;
      runCycles(1);
      checkOutput("rst_mid_valid", 48'(out_valid), 48'd0);
      checkOutput("rst_mid_f", 48'(f_out), 48'd0);
      checkOutput("rst_mid_ready", 48'(in_ready), 48'd1);
      rst = 1'b0;
      out_ready = 1'b1;
      runCycles(3);
      checkOutput("rst_nostale", 48'(out_valid), 48'd0);

      // Random traffic with random backpressure.
      startCount = accepted;
      for (int i = 0; i < 8000 && accepted < startCount + 1000; i++) begin
         if (!in_valid && $urandom_range(0, 3) != 0) begin
            rk = {16'($urandom), $urandom};
            applyStimulus(1'b1, $urandom, rk);
         end
         out_ready = ($urandom_range(0, 3) != 0);
         runCycles(1);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      runCycles(LAT + 3);
      checkOutput("random_count", 48'(accepted - startCount), 48'd1000);
      checkOutput("random_drain_valid", 48'(out_valid), 48'd0);
      checkOutput("random_drain_queue", 48'(sbq.size()), 48'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
